// File: rtl/uart_16550_tx_serializer.sv
// UART 16550 transmit serializer: pops one character from the Tx FIFO and frames it on SOUT.
// Parity generation is built only when the macro UART_TX_PARITY_EN is defined.
module uart_16550_tx_serializer #(
   parameter int TICKS_PER_BIT = 16
) (
   input  logic       WBs_CLK_i,
   input  logic       WBs_RSTn_i,
   input  logic       Baud_16x_En_i,
   input  logic       Tx_FIFO_Empty_i,
   input  logic [7:0] Tx_FIFO_DAT_i,
   output logic       Tx_FIFO_Pop_o,
   input  logic [1:0] LCR_WLS_i,
   input  logic       LCR_STB_i,
   input  logic       LCR_PEN_i,
   input  logic       LCR_EPS_i,
   input  logic       LCR_SP_i,
   input  logic       LCR_BC_i,
   output logic       SOUT_o,
   output logic       Tx_Busy_o,
   output logic       TEMT_o
);

   localparam int CNT_W = $clog2(2 * TICKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_1P0 = CNT_W'(TICKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] LAST_1P5 = CNT_W'(TICKS_PER_BIT * 3 / 2 - 1);
   localparam logic [CNT_W-1:0] LAST_2P0 = CNT_W'(2 * TICKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [1:0]       wls_q, wls_d;
   logic             stb_q, stb_d;
   logic             sout_q, sout_d;
   logic             temt_q, temt_d;
   logic             start_frame, tick_last;

`ifdef UART_TX_PARITY_EN
   logic       pen_q, pen_d;
   logic       par_q, par_d;
   logic [7:0] par_mask;
   logic       par_xor, par_bit;

   // Parity is resolved at pop time over only the configured word bits.
   assign par_mask = 8'hFF >> (2'd3 - LCR_WLS_i);
   assign par_xor  = ^(Tx_FIFO_DAT_i & par_mask);
   assign par_bit  = LCR_SP_i ? ~LCR_EPS_i : (LCR_EPS_i ? par_xor : ~par_xor);
`else
   logic unused_parity_cfg;
   assign unused_parity_cfg = ^{LCR_PEN_i, LCR_EPS_i, LCR_SP_i};
`endif

   assign start_frame = (state_q == ST_IDLE) && Baud_16x_En_i && !Tx_FIFO_Empty_i;
   assign cnt_last    = (state_q == ST_STOP && stb_q) ?
                        ((wls_q == 2'b00) ? LAST_1P5 : LAST_2P0) : LAST_1P0;
   assign tick_last   = Baud_16x_En_i && (cnt_q == cnt_last);

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
      if (!WBs_RSTn_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         wls_q     <= '0;
         stb_q     <= 1'b0;
         sout_q    <= 1'b1;
         temt_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         pen_q     <= 1'b0;
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         wls_q     <= wls_d;
         stb_q     <= stb_d;
         sout_q    <= sout_d;
         temt_q    <= temt_d;
`ifdef UART_TX_PARITY_EN
         pen_q     <= pen_d;
         par_q     <= par_d;
`endif
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first, so no path infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      wls_d     = wls_q;
      stb_d     = stb_q;
`ifdef UART_TX_PARITY_EN
      pen_d     = pen_q;
      par_d     = par_q;
`endif
      if (Baud_16x_En_i && state_q != ST_IDLE) begin
         cnt_d = tick_last ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
         ST_IDLE: begin
            if (start_frame) begin
               state_d = ST_START;
               cnt_d   = '0;
               shift_d = Tx_FIFO_DAT_i;
               wls_d   = LCR_WLS_i;
               stb_d   = LCR_STB_i;
`ifdef UART_TX_PARITY_EN
               pen_d   = LCR_PEN_i;
               par_d   = par_bit;
`endif
            end
         end
         ST_START: begin
            if (tick_last) begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
            end
         end
         ST_DATA: begin
            if (tick_last) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == {1'b0, wls_q} + 3'd4) begin
`ifdef UART_TX_PARITY_EN
                  state_d = pen_q ? ST_PARITY : ST_STOP;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick_last) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (tick_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line level is derived from the next state so each bit appears the clock after its tick.
   always_comb begin
      sout_d = 1'b1;
      case (state_d)
         ST_START:  sout_d = 1'b0;
         ST_DATA:   sout_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: sout_d = par_q;
`endif
         default:   sout_d = 1'b1;
      endcase
      if (LCR_BC_i) sout_d = 1'b0;
      temt_d = Tx_FIFO_Empty_i && (state_d == ST_IDLE);
   end

   assign Tx_FIFO_Pop_o = start_frame && WBs_RSTn_i;
   assign SOUT_o        = sout_q;
   assign Tx_Busy_o     = (state_q != ST_IDLE);
   assign TEMT_o        = temt_q;

endmodule

// File: tb/tb_uart_16550_tx_serializer.sv
// Directed bench for uart_16550_tx_serializer: table of framed characters plus break,
// baud-freeze, back-to-back and mid-frame reset sequences.
module tb_uart_16550_tx_serializer;

   logic       clk, rst_n, baud, empty, pop, sout, busy, temt;
   logic [7:0] dat;
   logic [1:0] wls;
   logic       stb, pen, eps, sp, bc;

   uart_16550_tx_serializer #(.TICKS_PER_BIT(16)) dut (
      .WBs_CLK_i       (clk),
      .WBs_RSTn_i      (rst_n),
      .Baud_16x_En_i   (baud),
      .Tx_FIFO_Empty_i (empty),
      .Tx_FIFO_DAT_i   (dat),
      .Tx_FIFO_Pop_o   (pop),
      .LCR_WLS_i       (wls),
      .LCR_STB_i       (stb),
      .LCR_PEN_i       (pen),
      .LCR_EPS_i       (eps),
      .LCR_SP_i        (sp),
      .LCR_BC_i        (bc),
      .SOUT_o          (sout),
      .Tx_Busy_o       (busy),
      .TEMT_o          (temt)
   );

   typedef struct {
      string       name;
      logic [7:0]  data;
      logic [1:0]  wls;
      logic        stb, pen, eps, sp;
      logic [11:0] bits;   // transmitted order, bit 0 = start bit
      int          nbits;
      int          clks;   // clocks from start-bit fall to return to idle
   } vec_t;

   vec_t       vecs[7];
   int         errors = 0;
   int         checks = 0;
   int         pop_total = 0;
   logic       pop_seen = 1'b0;
   bit         freeze = 1'b0;
   int         baud_cnt = 0;
   logic [7:0] fifo[$];
   logic       sout_w[0:2047];
   logic       busy_w[0:2047];
   logic       temt_w[0:2047];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO model with a registered empty flag; baud enable pulses one clock in four.
   initial begin
      baud  = 1'b0;
      empty = 1'b1;
      dat   = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
         empty = (fifo.size() == 0);
         dat   = empty ? 8'h00 : fifo[0];
         if (!freeze) baud_cnt = (baud_cnt + 1) % 4;
         baud = !freeze && (baud_cnt == 0);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         pop_seen = pop;
         if (pop === 1'b1) pop_total++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (sout === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Samples one entry per negedge starting at the current one; can toggle break/freeze on the way.
   task automatic record(input int n, input int bc_on, input int bc_off,
                         input int frz_on, input int frz_off);
      for (int c = 0; c < n; c++) begin
         if (c > 0) @(negedge clk);
         sout_w[c] = sout;
         busy_w[c] = busy;
         temt_w[c] = temt;
         if (c == bc_on)   bc = 1'b1;
         if (c == bc_off)  bc = 1'b0;
         if (c == frz_on)  freeze = 1'b1;
         if (c == frz_off) freeze = 1'b0;
      end
   endtask

   function automatic int first_idle(input int from, input int n);
      for (int c = from; c < n; c++) if (busy_w[c] === 1'b0) return c;
      return -1;
   endfunction

   task automatic set_lcr(input logic [1:0] w, input logic s, input logic p,
                          input logic e, input logic k);
      wls = w; stb = s; pen = p; eps = e; sp = k;
   endtask

   task automatic run_vec(input vec_t v);
      int          p0, fall;
      bit          ok;
      logic [11:0] cap;
      set_lcr(v.wls, v.stb, v.pen, v.eps, v.sp);
      p0 = pop_total;
      fifo.push_back(v.data);
      wait_start(ok);
      check({v.name, " start"}, 32'(ok), 32'd1);
      if (ok) begin
         record(v.clks + 8, -1, -1, -1, -1);
         cap = '0;
         for (int j = 0; j < v.nbits; j++) cap[j] = sout_w[64*j + 32];
         fall = first_idle(0, v.clks + 8);
         check({v.name, " bits"}, 32'(cap), 32'(v.bits));
         check({v.name, " frame_clks"}, 32'(fall), 32'(v.clks));
         check({v.name, " temt_mid"}, 32'(temt_w[32]), 32'd0);
         check({v.name, " temt_end"}, 32'(temt_w[v.clks]), 32'd1);
         check({v.name, " pops"}, 32'(pop_total - p0), 32'd1);
      end
   endtask

   initial begin
      bit          ok;
      int          p0, c2, fall, temt_hi;
      logic [11:0] cap;

      vecs[0] = '{"8N1_55", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 12'b0010_1010_1010, 10, 640};
      vecs[2] = '{"5N2_1F", 8'h1F, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 12'b0000_0111_1110, 7, 480};
      vecs[3] = '{"6N2_2A", 8'h2A, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 12'b0000_1101_0100, 8, 576};
`ifdef UART_TX_PARITY_EN
      vecs[1] = '{"7E1_83", 8'h83, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 12'b0010_0000_0110, 10, 640};
      vecs[4] = '{"8O1_03", 8'h03, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 12'b0110_0000_0110, 11, 704};
      vecs[5] = '{"5E1_FF", 8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 12'b0000_1111_1110, 8, 512};
      vecs[6] = '{"7S_7F",  8'h7F, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 12'b0010_1111_1110, 10, 640};
`else
      vecs[1] = '{"7E1_83", 8'h83, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 12'b0001_0000_0110, 9, 576};
      vecs[4] = '{"8O1_03", 8'h03, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 12'b0010_0000_0110, 10, 640};
      vecs[5] = '{"5E1_FF", 8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 12'b0000_0111_1110, 7, 448};
      vecs[6] = '{"7S_7F",  8'h7F, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 12'b0001_1111_1110, 9, 576};
`endif

      rst_n = 1'b0;
      bc    = 1'b0;
      set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      #12;
      check("reset sout", 32'(sout), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset temt", 32'(temt), 32'd1);
      check("reset pop",  32'(pop),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Back-to-back characters: one gap of a single tick period, TEMT low until the end.
      set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      p0 = pop_total;
      fifo.push_back(8'hA5);
      fifo.push_back(8'h3C);
      wait_start(ok);
      check("b2b start", 32'(ok), 32'd1);
      if (ok) begin
         record(1300, -1, -1, -1, -1);
         cap = '0;
         for (int j = 0; j < 10; j++) cap[j] = sout_w[64*j + 32];
         check("b2b first bits", 32'(cap), 32'h34A);
         c2 = -1;
         for (int c = 576; c < 1300; c++) if (c2 < 0 && sout_w[c] === 1'b0) c2 = c;
         check("b2b gap", 32'(c2 - 640), 32'd4);
         if (c2 >= 0 && c2 + 648 < 1300) begin
            cap = '0;
            for (int j = 0; j < 10; j++) cap[j] = sout_w[c2 + 64*j + 32];
            check("b2b second bits", 32'(cap), 32'h278);
            fall = first_idle(c2, 1300);
            check("b2b second len", 32'(fall - c2), 32'd640);
            temt_hi = 0;
            for (int c = 0; c < c2 + 640; c++) if (temt_w[c] !== 1'b0) temt_hi++;
            check("b2b temt low", 32'(temt_hi), 32'd0);
            check("b2b temt end", 32'(temt_w[c2 + 640]), 32'd1);
         end
         check("b2b pops", 32'(pop_total - p0), 32'd2);
      end
      repeat (8) @(negedge clk);

      // Break mid-DATA: line forced low one clock later, frame still completes on time.
      fifo.push_back(8'hFF);
      wait_start(ok);
      check("brk start", 32'(ok), 32'd1);
      if (ok) begin
         record(648, 200, 645, -1, -1);
         check("brk before", 32'(sout_w[200]), 32'd1);
         check("brk forced", 32'(sout_w[201]), 32'd0);
         check("brk stop low", 32'(sout_w[620]), 32'd0);
         check("brk frame_clks", 32'(first_idle(0, 648)), 32'd640);
         check("brk released", 32'(sout_w[646]), 32'd1);
      end
      repeat (8) @(negedge clk);

      // Baud enable held low for 90 clocks: SOUT holds and the frame stretches by exactly that.
      p0 = pop_total;
      fifo.push_back(8'h55);
      wait_start(ok);
      check("frz start", 32'(ok), 32'd1);
      if (ok) begin
         record(740, -1, -1, 100, 190);
         check("frz hold", 32'(sout_w[189]), 32'd1);
         check("frz frame_clks", 32'(first_idle(0, 740)), 32'd730);
         check("frz pops", 32'(pop_total - p0), 32'd1);
      end
      repeat (8) @(negedge clk);

      // Reset mid-DATA: outputs return to idle with no clock edge, nothing popped afterwards.
      fifo.push_back(8'h00);
      wait_start(ok);
      check("rst start", 32'(ok), 32'd1);
      if (ok) begin
         repeat (200) @(negedge clk);
         check("rst mid sout low", 32'(sout), 32'd0);
         #1 rst_n = 1'b0;
         #1;
         check("rst async sout", 32'(sout), 32'd1);
         check("rst async busy", 32'(busy), 32'd0);
         check("rst async temt", 32'(temt), 32'd1);
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         p0 = pop_total;
         record(200, -1, -1, -1, -1);
         temt_hi = 0;
         for (int c = 0; c < 200; c++) if (sout_w[c] !== 1'b1 || busy_w[c] !== 1'b0) temt_hi++;
         check("rst idle after", 32'(temt_hi), 32'd0);
         check("rst no pop", 32'(pop_total - p0), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_16550_tx_serializer.md
Name: uart_16550_tx_serializer

Overview:
- Transmit shift engine of the UART 16550, directly downstream of the Tx FIFO.
- Pops one character at a time from the FIFO and frames it as start, 5-8 data bits (LSB first), optional parity and 1/1.5/2 stop bits.
- Drives SOUT, one bit time per 16 ticks of the 16x baud enable.
- Reports transmitter-empty status (TEMT) to the LSR logic.

Parameters:
- TICKS_PER_BIT, 16, Baud_16x_En_i pulses per bit time; 1.5-stop length = TICKS_PER_BIT*3/2.

Ports:
- WBs_CLK_i  in  1  fabric clock, single clock domain.
- WBs_RSTn_i  in  1  reset, asynchronous, active-low.
- Baud_16x_En_i  in  1  one-clock pulse at 16x the baud rate.
- Tx_FIFO_Empty_i  in  1  FIFO empty flag, registered; updates the clock after a pop.
- Tx_FIFO_DAT_i  in  8  FIFO head data, valid whenever Empty=0 (first-word fall-through).
- Tx_FIFO_Pop_o  out  1  one-clock pop strobe.
- LCR_WLS_i  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
- LCR_STB_i  in  1  0 = 1 stop bit; 1 = 2 stop bits (1.5 when WLS=00).
- LCR_PEN_i  in  1  parity enable.
- LCR_EPS_i  in  1  1 = even parity, 0 = odd.
- LCR_SP_i  in  1  stick parity.
- LCR_BC_i  in  1  break control.
- SOUT_o  out  1  serial output, registered.
- Tx_Busy_o  out  1  1 whenever state != IDLE.
- TEMT_o  out  1  FIFO empty and shifter idle, registered.

Behaviour:
- Reset (WBs_RSTn_i=0, asynchronous, any state):
  - outputs: SOUT_o=1, Tx_FIFO_Pop_o=0, Tx_Busy_o=0, TEMT_o=1;
  - state=IDLE, tick counter=0, shift register=0.
  - Reset mid-frame aborts the character; SOUT returns to 1 immediately.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - SOUT=1.
  - On a cycle with Baud_16x_En_i=1 and Tx_FIFO_Empty_i=0: assert Tx_FIFO_Pop_o for exactly that cycle.
  - Same cycle: capture Tx_FIFO_DAT_i into the shift register and latch WLS/STB/PEN/EPS/SP for the whole character.
  - Next state START; tick counter cleared.
- Tick counter: counts only on Baud_16x_En_i cycles. A state ends on the cycle of its Nth tick counted after entry; SOUT for the next bit appears on the following clock.
- START: SOUT=0 for 16 ticks -> DATA, bit index=0.
- DATA:
  - SOUT=shift[0] for 16 ticks, then shift right and increment index.
  - After bit (WLS+5)-1: go to PARITY if PEN=1, else STOP.
- PARITY: bit = SP ? ~EPS : (EPS ? ^data[n-1:0] : ~^data[n-1:0]), where n = word length and only the n configured bits count. Held 16 ticks -> STOP.
- STOP: SOUT=1 for 16 ticks (STB=0), 24 ticks (STB=1, WLS=00) or 32 ticks (STB=1 otherwise) -> IDLE.
- Back-to-back characters: IDLE pops on the next tick after the STOP exit. The inter-frame gap is at most one tick period.
- No pop ever occurs outside IDLE.
- Only one pop per character. The FIFO empty flag is not re-examined until the next IDLE.
- Break: LCR_BC_i=1 forces SOUT_o=0 combinationally ahead of the output register, i.e. the effect is registered with one clock latency. The FSM keeps running, so the character in flight is consumed and lost on the line.
- TEMT_o <= Tx_FIFO_Empty_i & (next state == IDLE). It deasserts the clock after the pop.
- A FIFO flush during a frame does not affect the character already in the shift register.
- Baud_16x_En_i stuck at 0: the FSM freezes and SOUT holds its value.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state and LCR_PEN_i/LCR_EPS_i/LCR_SP_i are honoured as described above.
- Undefined:
  - PARITY state and parity logic are not built;
  - LCR_PEN_i, LCR_EPS_i and LCR_SP_i are ignored;
  - DATA always proceeds to STOP.
  - Ports remain present for interface compatibility.

Test Plan:
- Common setup: Baud_16x_En_i pulses 1 clock in every 4.
- 8N1: WLS=11, PEN=0, STB=0; FIFO holds 0x55 -> one pop pulse. SOUT = 0,1,0,1,0,1,0,1,0,1 LSB first, each bit 64 clocks (16 ticks). TEMT_o=1 after the stop bit.
- 7E1 (macro defined): WLS=10, PEN=1, EPS=1; data 0x83 -> 7 data bits of 0x03, then parity 0. Frame is 10 bits.
- 5-bit, STB=1: WLS=00, data 0x1F -> stop high for 24 ticks (96 clocks).
- 6-bit, STB=1: WLS=01 -> stop high for 32 ticks.
- Back-to-back: push 0xA5 then 0x3C -> exactly two pops. Second start bit begins at most 4 clocks after the first stop ends. TEMT_o=0 throughout, 1 at the end.
- Break and reset:
  - LCR_BC_i=1 mid-DATA -> SOUT_o=0 from the next clock. The FSM still reaches IDLE after the frame length.
  - Assert WBs_RSTn_i=0 mid-DATA -> SOUT_o=1, Tx_Busy_o=0, TEMT_o=1 immediately without a clock edge. No pop on release while the FIFO is empty.
